board_input_conditioner: RTL

//  Input-side companion to the board top level: takes raw KEY push-buttons and SW slide switches,

---
 rtl/board_io_pkg.sv | 17 +
 rtl/key_debounce_cell.sv | 101 ++++++++++
 rtl/board_input_conditioner.sv | 84 ++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// Shared constants and types for the board input conditioning path.
// Defaults assume a 50 MHz system clock.
package board_io_pkg;

   localparam int DEBOUNCE_DEFAULT = 1000000;
   localparam int LONG_DEFAULT     = 50000000;
   localparam int SAMPLE_DEFAULT   = 500000;

   localparam logic KEY_PRESSED = 1'b1;

   typedef enum logic [1:0] {
      LP_IDLE,
      LP_HOLD,
      LP_FIRED
   } lp_state_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One push-button: 2-FF sync, debounce counter, long-press FSM.
// Emits the clean level plus press/release/long single-cycle pulses.
module key_debounce_cell
   import board_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int LONG_CYCLES     = LONG_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic level,
   output logic rise,
   output logic fall,
   output logic long_hit
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] LP_LAST = LW'(LONG_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [DW-1:0] cnt;
   logic          accept;
   logic          press_evt;
   logic          rel_evt;

   lp_state_t     state;
   lp_state_t     state_nx;
   logic [LW-1:0] hold;
   logic [LW-1:0] hold_nx;
   logic          long_nx;

   assign accept    = (sync != level) && (cnt == DB_LAST);
   assign press_evt = accept && (sync == KEY_PRESSED);
   assign rel_evt   = accept && (sync != KEY_PRESSED);

   // stored in pressed polarity so a cleared sync stage reads as released
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta  <= 1'b0;
         sync  <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         meta <= ~key_n;
         sync <= meta;
         rise <= press_evt;
         fall <= rel_evt;
         if (sync == level || accept) cnt <= '0;
         else                         cnt <= cnt + DW'(1);
         if (accept) level <= sync;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= LP_IDLE;
         hold     <= '0;
         long_hit <= 1'b0;
      end else begin
         state    <= state_nx;
         hold     <= hold_nx;
         long_hit <= long_nx;
      end
   end

   // a release on the threshold cycle suppresses the long pulse
   always_comb begin
      state_nx = state;
      hold_nx  = hold;
      long_nx  = 1'b0;
      unique case (state)
         LP_IDLE: begin
            if (press_evt) begin
               state_nx = LP_HOLD;
               hold_nx  = '0;
            end
         end
         LP_HOLD: begin
            if (rel_evt) begin
               state_nx = LP_IDLE;
            end else if (hold == LP_LAST) begin
               long_nx  = 1'b1;
               state_nx = LP_FIRED;
            end else begin
               hold_nx = hold + LW'(1);
            end
         end
         LP_FIRED: begin
            if (rel_evt) state_nx = LP_IDLE;
         end
         default: state_nx = LP_IDLE;
      endcase
   end

endmodule

// File: rtl/board_input_conditioner.sv
// Board pin conditioner: per-key debounce cells plus a sampled
// switch path with a shared prescaler and two-sample agreement.
module board_input_conditioner
   import board_io_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int N_SW            = 18,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int LONG_CYCLES     = LONG_DEFAULT,
   parameter int SW_SAMPLE       = SAMPLE_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_n,
   input  logic [N_SW-1:0]   sw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long,
   output logic [N_SW-1:0]   sw_level,
   output logic [N_SW-1:0]   sw_change
);

   localparam int PW = (SW_SAMPLE > 1) ? $clog2(SW_SAMPLE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(SW_SAMPLE - 1);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      key_debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_cell (
         .clk      (clk),
         .reset    (reset),
         .key_n    (key_n[g]),
         .level    (key_level[g]),
         .rise     (key_press[g]),
         .fall     (key_release[g]),
         .long_hit (key_long[g])
      );
   end

   logic [PW-1:0]   pre;
   logic            tick;
   logic [N_SW-1:0] sw_meta;
   logic [N_SW-1:0] sw_sync;
   logic [N_SW-1:0] sw_samp;
   logic [N_SW-1:0] sw_flip;
   logic            sw_seen;
   logic            sw_primed;

   assign tick    = (pre == PRE_LAST);
   assign sw_flip = ~(sw_sync ^ sw_samp) & (sw_sync ^ sw_level);

   // first two ticks load the level silently so power-up state is not an event
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre       <= '0;
         sw_meta   <= '0;
         sw_sync   <= '0;
         sw_samp   <= '0;
         sw_level  <= '0;
         sw_change <= '0;
         sw_seen   <= 1'b0;
         sw_primed <= 1'b0;
      end else begin
         sw_meta   <= sw;
         sw_sync   <= sw_meta;
         pre       <= tick ? '0 : pre + PW'(1);
         sw_change <= '0;
         if (tick) begin
            sw_samp <= sw_sync;
            if (!sw_primed) begin
               sw_level  <= sw_sync;
               sw_seen   <= 1'b1;
               sw_primed <= sw_seen;
            end else begin
               sw_level  <= sw_level ^ sw_flip;
               sw_change <= sw_flip;
            end
         end
      end
   end

endmodule
